// File: rtl/qam_pkg.sv
// qam_pkg -- shared definitions for the QAM mapper.
//   qam_mode_e   : modulation select (BPSK, QPSK, 16QAM, 64QAM)
//   BPS_TABLE    : bits consumed per symbol, indexed by mode
//   LEVEL_16QAM  : Gray level per 2-bit axis code (first bit is the sign)
//   LEVEL_64QAM  : Gray level per 3-bit axis code (first bit is the sign)
//   k_mode()     : per-mode scale factor round(2^(NUM_WIDTH-2) / sqrt(d))
package qam_pkg;

    typedef enum logic [1:0] {
        MODE_BPSK  = 2'd0,
        MODE_QPSK  = 2'd1,
        MODE_16QAM = 2'd2,
        MODE_64QAM = 2'd3
    } qam_mode_e;

    localparam int unsigned BPS_TABLE [4] = '{1, 2, 4, 6};

    localparam logic signed [3:0] LEVEL_16QAM [4] = '{4'sd1, 4'sd3, -4'sd1, -4'sd3};

    localparam logic signed [3:0] LEVEL_64QAM [8] =
        '{4'sd3, 4'sd1, 4'sd5, 4'sd7, -4'sd3, -4'sd1, -4'sd5, -4'sd7};

    function automatic logic [2:0] bps_of(input qam_mode_e m);
        return 3'(BPS_TABLE[int'(m)]);
    endfunction

    // Integer square root, bit by bit; x stays below 2^60 for NUM_WIDTH <= 31.
    function automatic longint isqrt(input longint x);
        longint r;
        longint c;
        r = 0;
        for (int b = 30; b >= 0; b--) begin
            c = r | (longint'(1) << b);
            if (c * c <= x) r = c;
        end
        return r;
    endfunction

    // Elaboration-time only. Normalisation divisor d is 1, 2, 10, 42.
    // Rounds up when (2t+1)^2 * d <= 4^(NUM_WIDTH-1), i.e. t+0.5 <= 2^(N-2)/sqrt(d).
    function automatic longint k_mode(input qam_mode_e m, input int num_width);
        longint d;
        longint t;
        case (m)
            MODE_BPSK:  d = 1;
            MODE_QPSK:  d = 2;
            MODE_16QAM: d = 10;
            default:    d = 42;
        endcase
        t = isqrt((longint'(1) << (2 * (num_width - 2))) / d);
        if ((2 * t + 1) * (2 * t + 1) * d <= (longint'(1) << (2 * (num_width - 1))))
            t = t + 1;
        return t;
    endfunction

endpackage

// File: rtl/qam_level_scale.sv
// qam_level_scale -- combinational Gray level lookup and scaling.
//   mode      : active modulation
//   sym_bits  : oldest six accumulator bits, sym_bits[5] is first in time;
//               only the top BPS bits are meaningful for the mode
//   out_i/out_q : level * K_mode, exact product truncated to NUM_WIDTH
module qam_level_scale
    import qam_pkg::*;
#(
    parameter int NUM_WIDTH = 16
) (
    input  qam_mode_e                   mode,
    input  logic [5:0]                  sym_bits,
    output logic signed [NUM_WIDTH-1:0] out_i,
    output logic signed [NUM_WIDTH-1:0] out_q
);

    localparam int PW = NUM_WIDTH + 4;

    localparam logic signed [NUM_WIDTH-1:0] K_BPSK  = NUM_WIDTH'(k_mode(MODE_BPSK, NUM_WIDTH));
    localparam logic signed [NUM_WIDTH-1:0] K_QPSK  = NUM_WIDTH'(k_mode(MODE_QPSK, NUM_WIDTH));
    localparam logic signed [NUM_WIDTH-1:0] K_16QAM = NUM_WIDTH'(k_mode(MODE_16QAM, NUM_WIDTH));
    localparam logic signed [NUM_WIDTH-1:0] K_64QAM = NUM_WIDTH'(k_mode(MODE_64QAM, NUM_WIDTH));

    logic signed [3:0]           lvl_i;
    logic signed [3:0]           lvl_q;
    logic signed [NUM_WIDTH-1:0] k;
    logic signed [PW-1:0]        prod_i;
    logic signed [PW-1:0]        prod_q;

    always_comb begin
        lvl_i = 4'sd0;
        lvl_q = 4'sd0;
        k     = K_BPSK;
        case (mode)
            MODE_BPSK: begin
                lvl_i = sym_bits[5] ? -4'sd1 : 4'sd1;
                k     = K_BPSK;
            end
            MODE_QPSK: begin
                lvl_i = sym_bits[5] ? -4'sd1 : 4'sd1;
                lvl_q = sym_bits[4] ? -4'sd1 : 4'sd1;
                k     = K_QPSK;
            end
            MODE_16QAM: begin
                lvl_i = LEVEL_16QAM[sym_bits[5:4]];
                lvl_q = LEVEL_16QAM[sym_bits[3:2]];
                k     = K_16QAM;
            end
            default: begin
                lvl_i = LEVEL_64QAM[sym_bits[5:3]];
                lvl_q = LEVEL_64QAM[sym_bits[2:0]];
                k     = K_64QAM;
            end
        endcase
        // |level*K| never exceeds ~1.09 * 2^(NUM_WIDTH-2), so truncation is lossless.
        prod_i = PW'(lvl_i) * PW'(k);
        prod_q = PW'(lvl_q) * PW'(k);
        out_i  = prod_i[NUM_WIDTH-1:0];
        out_q  = prod_q[NUM_WIDTH-1:0];
    end

endmodule

// File: rtl/qam_mapper.sv
// qam_mapper -- bit accumulator feeding a BPSK/QPSK/16QAM/64QAM symbol mapper.
//   clk, reset        : rising-edge clock, asynchronous active-high reset
//   in_data/in_valid/in_ready : coded input words, MSB first in time
//   flush             : pulse; zero-pads residual bits to a whole symbol
//   rate_id           : modulation select, latched only while idle
//   out_i/out_q/out_valid/out_ready : registered signed I/Q symbols
//   busy              : accumulator non-empty or a symbol is pending
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds data stable while valid is high and ready is
// low; the output register obeys this (out_* hold while stalled). in_ready
// depends only on registered state, never on in_valid or out_ready.
module qam_mapper
    import qam_pkg::*;
#(
    parameter int NUM_WIDTH = 16,
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 16   // must be at least IN_WIDTH+5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [IN_WIDTH-1:0]         in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        flush,
    input  logic [1:0]                  rate_id,
    output logic signed [NUM_WIDTH-1:0] out_i,
    output logic signed [NUM_WIDTH-1:0] out_q,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy
);

    // cnt can exceed ACC_WIDTH by up to 5 after padding a full accumulator;
    // padded bits live past the physical end and read back as zeros.
    localparam int CW = $clog2(2 * ACC_WIDTH + 1) + 1;

    qam_mode_e                   mode;
    logic [ACC_WIDTH-1:0]        acc;       // oldest bit at the MSB, unused bits kept zero
    logic [CW-1:0]               cnt;
    logic [ACC_WIDTH-1:0]        acc_nxt;
    logic [CW-1:0]               cnt_nxt;
    logic [CW-1:0]               bps;
    logic [CW-1:0]               rem;
    logic [ACC_WIDTH-1:0]        word_aligned;
    logic                        accept;
    logic                        take;
    logic signed [NUM_WIDTH-1:0] sym_i;
    logic signed [NUM_WIDTH-1:0] sym_q;

    assign bps          = CW'(bps_of(mode));
    assign in_ready     = (cnt + CW'(IN_WIDTH)) <= CW'(ACC_WIDTH);
    assign accept       = in_valid && in_ready;
    assign take         = (cnt >= bps) && (!out_valid || out_ready);
    assign busy         = (cnt != '0) || out_valid;
    assign word_aligned = {in_data, {(ACC_WIDTH - IN_WIDTH){1'b0}}};

    qam_level_scale #(
        .NUM_WIDTH (NUM_WIDTH)
    ) u_level_scale (
        .mode     (mode),
        .sym_bits (acc[ACC_WIDTH-1 -: 6]),
        .out_i    (sym_i),
        .out_q    (sym_q)
    );

    // Order within a cycle: consume a symbol, append the new word behind the
    // remaining bits, then pad on flush.
    always_comb begin
        acc_nxt = acc;
        cnt_nxt = cnt;
        rem     = '0;
        if (take) begin
            acc_nxt = acc << bps;
            cnt_nxt = cnt - bps;
        end
        if (accept) begin
            acc_nxt = acc_nxt | (word_aligned >> cnt_nxt);
            cnt_nxt = cnt_nxt + CW'(IN_WIDTH);
        end
        if (flush && (cnt_nxt != '0)) begin
            rem = cnt_nxt % bps;
            if (rem != '0) cnt_nxt = cnt_nxt + bps - rem;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            cnt <= '0;
        end else begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
        end
    end

    // Mode may only change while nothing is buffered, so a symbol never
    // mixes bits from two modes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode <= MODE_BPSK;
        end else if ((cnt == '0) && !accept) begin
            mode <= qam_mode_e'(rate_id);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_i     <= '0;
            out_q     <= '0;
            out_valid <= 1'b0;
        end else if (take) begin
            out_i     <= sym_i;
            out_q     <= sym_q;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_qam_mapper.sv
// tb_qam_mapper -- directed and randomized bench for qam_mapper
// (NUM_WIDTH=16, IN_WIDTH=8, ACC_WIDTH=16).
module tb_qam_mapper;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [1:0]        rate_id;
    logic signed [15:0] out_i;
    logic signed [15:0] out_q;
    logic              out_valid;
    logic              out_ready;
    logic              busy;

    always #5 clk = ~clk;

    qam_mapper #(
        .NUM_WIDTH (16),
        .IN_WIDTH  (8),
        .ACC_WIDTH (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .rate_id   (rate_id),
        .out_i     (out_i),
        .out_q     (out_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    logic [31:0] exp_q[$];     // {I[15:0], Q[15:0]} in emission order
    bit          bq[$];        // reference bit stream, front is oldest
    int          cur_mode = 0;
    bit          model_on = 1'b0;
    int          k_tab[4];

    logic               stall_seen = 1'b0;
    logic signed [15:0] stall_i = '0;
    logic signed [15:0] stall_q = '0;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int bps_m(input int m);
        case (m)
            0: return 1;
            1: return 2;
            2: return 4;
            default: return 6;
        endcase
    endfunction

    // Axis level from n bits, first bit in time is the MSB of v and the sign.
    function automatic int lvl(input int n, input int v);
        int mag;
        int s;
        if (n == 1) return (v != 0) ? -1 : 1;
        if (n == 2) begin
            s   = (v >> 1) & 1;
            mag = ((v & 1) != 0) ? 3 : 1;
        end else begin
            s = (v >> 2) & 1;
            case (v & 3)
                0: mag = 3;
                1: mag = 1;
                2: mag = 5;
                default: mag = 7;
            endcase
        end
        return (s != 0) ? -mag : mag;
    endfunction

    function automatic void push_exp(input int i, input int q);
        exp_q.push_back({i[15:0], q[15:0]});
    endfunction

    function automatic void model_emit();
        int b;
        int v;
        int li;
        int lq;
        b = bps_m(cur_mode);
        v = 0;
        for (int i = 0; i < b; i++) v = (v << 1) | int'(bq.pop_front());
        case (cur_mode)
            0: begin li = lvl(1, v);      lq = 0;             end
            1: begin li = lvl(1, v >> 1); lq = lvl(1, v & 1); end
            2: begin li = lvl(2, v >> 2); lq = lvl(2, v & 3); end
            default: begin li = lvl(3, v >> 3); lq = lvl(3, v & 7); end
        endcase
        push_exp(li * k_tab[cur_mode], lq * k_tab[cur_mode]);
    endfunction

    function automatic void model_word(input logic [7:0] d);
        if (!model_on) return;
        for (int i = 7; i >= 0; i--) bq.push_back(d[i]);
        while (bq.size() >= bps_m(cur_mode)) model_emit();
    endfunction

    function automatic void model_flush();
        if (!model_on) return;
        while ((bq.size() % bps_m(cur_mode)) != 0) bq.push_back(1'b0);
        while (bq.size() >= bps_m(cur_mode)) model_emit();
    endfunction

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            stall_seen <= 1'b0;
        end else begin
            if (stall_seen) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_i", out_i, stall_i);
                check("hold_q", out_q, stall_q);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_symbol", 32'(out_valid), 0);
                end else begin
                    check("sym_i", out_i, 32'(signed'(exp_q[0][31:16])));
                    check("sym_q", out_q, 32'(signed'(exp_q[0][15:0])));
                    void'(exp_q.pop_front());
                end
            end
            stall_seen <= out_valid && !out_ready;
            stall_i    <= out_i;
            stall_q    <= out_q;
        end
    end

    // ---------------- drivers ----------------
    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_word(input logic [7:0] d, input logic do_flush);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && guard < 200) begin
            if (guard > 3) out_ready = 1'b1;
            @(posedge clk); #1;
            guard++;
        end
        check("send_accept", 32'(in_ready), 1);
        flush = do_flush;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        model_word(d);
        if (do_flush) model_flush();
    endtask

    task automatic drain();
        int guard;
        guard     = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_flush();
        while (busy && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain_busy", 32'(busy), 0);
    endtask

    task automatic set_mode(input int m);
        rate_id = 2'(m);
        drain();
        @(posedge clk); #1;
        cur_mode = m;
    endtask

    // ---------------- stimulus ----------------
    localparam int KQ = 11585;
    localparam int K16 = 5181;

    initial begin
        k_tab[0] = $rtoi(16384.0 / $sqrt(1.0) + 0.5);
        k_tab[1] = $rtoi(16384.0 / $sqrt(2.0) + 0.5);
        k_tab[2] = $rtoi(16384.0 / $sqrt(10.0) + 0.5);
        k_tab[3] = $rtoi(16384.0 / $sqrt(42.0) + 0.5);

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        rate_id   = 2'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_i", out_i, 0);
        check("rst_out_q", out_q, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // QPSK 0x1B: four symbols on consecutive cycles, one cycle latency.
        set_mode(1);
        push_exp(KQ, KQ); push_exp(KQ, -KQ); push_exp(-KQ, KQ); push_exp(-KQ, -KQ);
        send_word(8'h1B, 1'b0);
        check("qpsk_latency", 32'(out_valid), 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("qpsk_consecutive", 32'(out_valid), 1);
        end
        @(posedge clk); #1;
        check("qpsk_done_valid", 32'(out_valid), 0);
        check("qpsk_done_busy", 32'(busy), 0);

        // 16QAM 0x5C.
        set_mode(2);
        push_exp(3 * K16, 3 * K16); push_exp(-3 * K16, K16);
        send_word(8'h5C, 1'b0);
        drain();

        // 16QAM with flush in the accepting cycle on an exact multiple: no pad.
        push_exp(3 * K16, 3 * K16); push_exp(-3 * K16, K16);
        send_word(8'h5C, 1'b1);
        drain();
        check("exact_flush_nopad", exp_q.size(), 0);

        // 64QAM 0xFF then flush.
        set_mode(3);
        push_exp(-17696, -17696); push_exp(-12640, 7584);
        send_word(8'hFF, 1'b0);
        drain();
        check("qam64_flush_left", exp_q.size(), 0);

        // Flush while idle is a no-op.
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_flush_busy", 32'(busy), 0);
        check("idle_flush_valid", 32'(out_valid), 0);

        // QPSK backpressure: symbol held, in_ready falls, nothing lost.
        set_mode(1);
        out_ready = 1'b0;
        push_exp(-KQ, KQ); push_exp(-KQ, -KQ); push_exp(KQ, -KQ); push_exp(KQ, KQ);
        push_exp(KQ, KQ); push_exp(-KQ, -KQ); push_exp(-KQ, -KQ); push_exp(KQ, KQ);
        send_word(8'hB4, 1'b0);
        send_word(8'h3C, 1'b0);
        check("bp_in_ready_low", 32'(in_ready), 0);
        for (int i = 0; i < 5; i++) begin
            check("bp_held_i", out_i, -KQ);
            check("bp_held_q", out_q, KQ);
            @(posedge clk); #1;
        end
        check("bp_still_blocked", 32'(in_ready), 0);
        drain();
        check("bp_all_symbols", exp_q.size(), 0);

        // rate_id changed mid-word is ignored; next word after drain is 16QAM.
        set_mode(1);
        push_exp(KQ, KQ); push_exp(KQ, -KQ); push_exp(-KQ, KQ); push_exp(-KQ, -KQ);
        send_word(8'h1B, 1'b0);
        rate_id = 2'd2;
        drain();
        @(posedge clk); #1;
        push_exp(3 * K16, 3 * K16); push_exp(-3 * K16, K16);
        send_word(8'h5C, 1'b0);
        drain();
        check("switch_left", exp_q.size(), 0);

        // Reset with 4 bits buffered and a symbol pending.
        set_mode(2);
        out_ready = 1'b0;
        send_word(8'hA5, 1'b0);
        @(posedge clk); #1;
        check("pre_rst_valid", 32'(out_valid), 1);
        check("pre_rst_busy", 32'(busy), 1);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_in_ready", 32'(in_ready), 1);
        exp_q.delete();
        bq.delete();
        @(posedge clk); #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_no_stale", 32'(out_valid), 0);
        check("post_rst_busy", 32'(busy), 0);

        // Randomized phases against the reference model.
        model_on = 1'b1;
        for (int p = 0; p < 14; p++) begin
            int nw;
            set_mode($urandom_range(0, 3));
            nw = $urandom_range(1, 5);
            for (int w = 0; w < nw; w++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                send_word(8'($urandom_range(0, 255)),
                          (w == nw - 1) && ($urandom_range(0, 1) == 1));
                repeat ($urandom_range(0, 2)) begin
                    out_ready = ($urandom_range(0, 1) == 1);
                    @(posedge clk); #1;
                end
            end
            drain();
            check("rand_phase_left", exp_q.size(), 0);
        end

        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/qam_mapper.md
QAM_MAPPER -- requirements
Module: qam_mapper

Interface
REQ-001 SHALL have parameter NUM_WIDTH, default 16: signed width of each I and Q output sample.
REQ-002 SHALL have parameter IN_WIDTH, default 8: input data word width in bits.
REQ-003 SHALL have parameter ACC_WIDTH, default 16: bit accumulator depth; must be at least IN_WIDTH+5.
REQ-004 SHALL have these ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  IN_WIDTH  coded bits; the MSB is the first bit in time.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  the mapper can accept a word.
- flush  input  1  single-cycle pulse; zero-pads the residual bits to one whole symbol.
- rate_id  input  2  modulation select: 0 BPSK, 1 QPSK, 2 16QAM, 3 64QAM.
- out_i  output  NUM_WIDTH  signed I sample.
- out_q  output  NUM_WIDTH  signed Q sample.
- out_valid  output  1  the symbol on out_i/out_q is valid.
- out_ready  input  1  downstream accepts the symbol.
- busy  output  1  the accumulator is non-empty or out_valid is high.

Function
REQ-005 An input transfer SHALL occur when in_valid and in_ready are both high; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-006 Bits per symbol (BPS) SHALL be 1, 2, 4 or 6 for modes 0, 1, 2 and 3 respectively.
REQ-007 The accepted word SHALL be appended behind the accumulator contents, MSB first; bit count cnt SHALL increase by IN_WIDTH.
REQ-008 in_ready SHALL be high when cnt+IN_WIDTH <= ACC_WIDTH, evaluated on the registered cnt; it SHALL NOT be credited with a symbol consumed in the same cycle.
REQ-009 When cnt >= BPS and the output register is empty or emptying (!out_valid or out_ready), the mapper SHALL take the oldest BPS bits, register the mapped I/Q and set out_valid.
- Rate: at most one symbol per cycle.
- Latency: the first symbol appears one cycle after the accepting edge.
REQ-010 out_i, out_q and out_valid SHALL hold stable while out_valid is high and out_ready is low.
REQ-011 Bit split (b0 is first in time):
- BPSK: b0 drives I; Q=0.
- QPSK: b0 drives I, b1 drives Q.
- 16QAM: b0b1 drive I, b2b3 drive Q.
- 64QAM: b0b1b2 drive I, b3b4b5 drive Q.
REQ-012 Levels (the first bit is the sign, 1 = negative):
- BPSK/QPSK: 0 -> +1, 1 -> -1.
- 16QAM: 00 -> +1, 01 -> +3, 10 -> -1, 11 -> -3.
- 64QAM: 000 -> +3, 001 -> +1, 010 -> +5, 011 -> +7, 100 -> -3, 101 -> -1, 110 -> -5, 111 -> -7.
REQ-013 Output SHALL be level * K_mode, where K_mode = round(2^(NUM_WIDTH-2) * c) and c = 1, 1/sqrt2, 1/sqrt10, 1/sqrt42.
- NUM_WIDTH=16 gives K = 16384, 11585, 5181, 2528.
- The product is computed exactly, then truncated to NUM_WIDTH without overflow.
REQ-014 The active mode SHALL be latched from rate_id only when cnt==0 and no input is being accepted in that cycle; rate_id changes at any other time SHALL be ignored.
REQ-015 flush with cnt>0 and cnt not a multiple of BPS SHALL zero-pad cnt up to the next multiple of BPS.
- flush with cnt==0 SHALL be a no-op.
- flush with cnt an exact multiple of BPS SHALL add no padding.
REQ-016 flush in the same cycle as an input transfer SHALL apply after the accepted word is appended.
REQ-017 busy SHALL equal (cnt!=0) or out_valid.

Reset
REQ-018 On reset, these SHALL be cleared asynchronously:
- cnt and the accumulator to 0.
- out_i and out_q to 0.
- out_valid to 0.
- busy to 0.
- mode to BPSK.
- in_ready to 1.
REQ-019 A reset asserted mid-symbol SHALL discard all buffered bits and any pending output; the next symbol SHALL come only from input accepted after reset deasserts.

Structure
REQ-020 A shared package qam_pkg SHALL hold:
- the mode enum;
- the BPS table;
- the K_mode constants as a function of NUM_WIDTH;
- the Gray level tables.
REQ-021 The level lookup and scaling SHALL be a combinational sub-module named qam_level_scale: inputs mode and 6 bits; outputs signed I and Q.

Verification (NUM_WIDTH=16, IN_WIDTH=8)
REQ-022 QPSK, in_data 0x1B, out_ready=1 -> four symbols (I,Q): (11585,11585), (11585,-11585), (-11585,11585), (-11585,-11585), on consecutive cycles.
REQ-023 16QAM, in_data 0x5C -> two symbols: (15543,15543), then (-15543,5181).
REQ-024 64QAM, in_data 0xFF then flush -> (-17696,-17696), then (-12640,7584); afterwards busy=0.
REQ-025 QPSK with out_ready held low for 5 cycles -> first symbol held stable; in_ready falls once cnt+8>16; no bit is lost after out_ready rises.
REQ-026 rate_id switched from QPSK to 16QAM mid-word -> remaining bits stay QPSK; the next word after the accumulator drains maps as 16QAM.
REQ-027 reset pulse asserted with 4 bits buffered and out_valid high -> out_valid=0, cnt=0 and in_ready=1 immediately, with no stale symbol emitted afterwards.
